// File: rtl/hilo_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

  // Default operand width; the result is twice this wide.
  localparam int HILO_WIDTH = 32;

  // Writeback flag that commits both HI and LO from the unit's result.
  localparam logic [2:0] HILO_WR_BOTH = 3'b111;

  // Operation encoding as presented on the op port.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Sequencer states.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  // True for the two divide operations.
  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // True for the operations that treat operands as two's complement.
  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Post-iteration correction: turns the unsigned magnitude result into the
// architectural {HI,LO} value (negation and divide-by-zero handling).
module muldiv_sign_fix
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic [2*WIDTH-1:0] raw,
  input  op_e                op,
  input  logic               sign_a,
  input  logic               sign_b,
  input  logic               b_zero,
  output logic [2*WIDTH-1:0] fixed
);

  logic [WIDTH-1:0] hi_s;
  logic [WIDTH-1:0] lo_s;
  logic [WIDTH-1:0] hi_fix_s;
  logic [WIDTH-1:0] lo_fix_s;

  // Select the correction for the operation that produced the raw value.
  always_comb begin
    hi_s     = raw[2*WIDTH-1:WIDTH];
    lo_s     = raw[WIDTH-1:0];
    hi_fix_s = hi_s;
    lo_fix_s = lo_s;
    fixed    = raw;
    case (op)
      OP_MULT: begin
        if (sign_a ^ sign_b) begin
          fixed = -raw;
        end else begin
          fixed = raw;
        end
      end
      OP_MULTU: begin
        fixed = raw;
      end
      OP_DIV: begin
        // With a zero divisor the remainder path leaves |a| in HI, so
        // re-applying the dividend sign restores the original operand.
        if (sign_a) begin
          hi_fix_s = -hi_s;
        end else begin
          hi_fix_s = hi_s;
        end
        if (b_zero) begin
          lo_fix_s = {WIDTH{1'b1}};
        end else if (sign_a ^ sign_b) begin
          lo_fix_s = -lo_s;
        end else begin
          lo_fix_s = lo_s;
        end
        fixed = {hi_fix_s, lo_fix_s};
      end
      OP_DIVU: begin
        if (b_zero) begin
          fixed = {hi_s, {WIDTH{1'b1}}};
        end else begin
          fixed = raw;
        end
      end
      default: begin
        fixed = raw;
      end
    endcase
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative radix-2 multiply/divide unit feeding the HI/LO write port.
// Fixed latency: one setup edge, WIDTH iteration edges, one finish edge.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               cancel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  op_e                op_r;
  logic               sign_a_r;
  logic               sign_b_r;
  logic               b_zero_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] result_r;
  logic               busy_r;
  logic               done_r;

  op_e                op_in_s;
  logic               signed_in_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_step_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH+1:0]   div_diff_s;
  logic               div_qbit_s;
  logic [2*WIDTH-1:0] div_step_s;
  logic [2*WIDTH-1:0] fixed_s;

  // Decode the incoming op and reduce operands to magnitudes for signed ops.
  always_comb begin
    op_in_s     = op_e'(op);
    signed_in_s = op_is_signed(op_in_s);
    if (signed_in_s && a[WIDTH-1]) begin
      mag_a_s = -a;
    end else begin
      mag_a_s = a;
    end
    if (signed_in_s && b[WIDTH-1]) begin
      mag_b_s = -b;
    end else begin
      mag_b_s = b;
    end
  end

  // Shift-add multiply step: acc = {partial HI, remaining multiplier bits}.
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    if (acc_r[0]) begin
      mul_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else begin
      mul_step_s = {1'b0, acc_r[2*WIDTH-1:1]};
    end
  end

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
  // The partial remainder is always below the divisor, so a successful trial
  // subtraction leaves both top bits of the difference clear.
  always_comb begin
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};
    div_qbit_s  = ~|div_diff_s[WIDTH+1:WIDTH];
    if (div_qbit_s) begin
      div_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
  end

  muldiv_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .raw    (acc_r),
    .op     (op_r),
    .sign_a (sign_a_r),
    .sign_b (sign_b_r),
    .b_zero (b_zero_r),
    .fixed  (fixed_s)
  );

  // Sequencer and datapath registers; cancel aborts from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      op_r     <= OP_MULT;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      b_zero_r <= 1'b0;
      opnd_r   <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      result_r <= {(2*WIDTH){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (cancel) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r     <= op_in_s;
            sign_a_r <= signed_in_s & a[WIDTH-1];
            sign_b_r <= signed_in_s & b[WIDTH-1];
            b_zero_r <= (b == {WIDTH{1'b0}});
            if (op_is_div(op_in_s)) begin
              opnd_r <= mag_b_s;
              acc_r  <= {{WIDTH{1'b0}}, mag_a_s};
            end else begin
              opnd_r <= mag_a_s;
              acc_r  <= {{WIDTH{1'b0}}, mag_b_s};
            end
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          if (op_is_div(op_r)) begin
            acc_r <= div_step_s;
          end else begin
            acc_r <= mul_step_s;
          end
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= FIN;
          end else begin
            state_r <= RUN;
          end
          busy_r <= 1'b1;
        end
        FIN: begin
          result_r <= fixed_s;
          done_r   <= 1'b1;
          state_r  <= IDLE;
          busy_r   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign stall  = busy_r | (start & ~cancel);

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed and random operations
// compared against an arithmetic reference model.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;

  hilo_muldiv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .cancel (cancel),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the architectural values.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = 64'h0;
    case (o)
      2'b00: p = sx * sy;
      2'b01: p = {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 32'h0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'h0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // Drive one operation from a negedge; return result, edges after the
  // accepting edge until done, and a count of busy/stall violations.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [63:0] res, output int lat, output int flagbad);
    flagbad = 0;
    lat     = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    #1;
    if (stall !== 1'b1) flagbad++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1 || stall !== 1'b1) flagbad++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (busy !== 1'b0) flagbad++;
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, stall} !== 3'b000 || result !== 64'h0) begin
      bad++;
      $display("FAIL reset busy=%b done=%b stall=%b result=%h, need 0/0/0/0", busy, done, stall, result);
    end
    rst = 1'b0;
  endtask

  task automatic test_mult();
    logic [1:0]  ops [3] = '{2'b01, 2'b00, 2'b00};
    logic [31:0] as  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000};
    logic [63:0] ex  [3] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1, 64'h4000_0000_0000_0000};
    logic [63:0] res, exp_v;
    logic [1:0]  o;
    logic [31:0] x, y;
    int lat, fb;
    for (int i = 0; i < 15; i++) begin
      if (i < 3) begin o = ops[i]; x = as[i]; y = bs[i]; exp_v = ex[i]; end
      else begin
        o = {1'b0, 1'($urandom_range(0, 1))}; x = $urandom; y = $urandom;
        exp_v = ref_model(o, x, y);
      end
      do_op(o, x, y, res, lat, fb);
      total++;
      if (res !== exp_v) begin
        bad++; $display("FAIL mult op=%0d a=%h b=%h got=%h need=%h", o, x, y, res, exp_v);
      end
      total++;
      if (lat !== 33 || fb !== 0) begin
        bad++; $display("FAIL mult_timing latency=%0d need 33, busy/stall errors=%0d need 0", lat, fb);
      end
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops [3] = '{2'b10, 2'b11, 2'b10};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd2, 32'd7, 32'hFFFF_FFFF};
    logic [63:0] ex  [3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E, 64'h0000_0000_8000_0000};
    logic [63:0] res, exp_v;
    logic [1:0]  o;
    logic [31:0] x, y;
    int lat, fb;
    for (int i = 0; i < 19; i++) begin
      if (i < 3) begin o = ops[i]; x = as[i]; y = bs[i]; exp_v = ex[i]; end
      else begin
        o = {1'b1, 1'($urandom_range(0, 1))};
        x = $urandom;
        y = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
        if ($urandom_range(0, 1) == 1) y = -y;
        if (y == 32'h0) y = 32'd3;
        exp_v = ref_model(o, x, y);
      end
      do_op(o, x, y, res, lat, fb);
      total++;
      if (res !== exp_v) begin
        bad++; $display("FAIL div op=%0d a=%h b=%h got=%h need=%h", o, x, y, res, exp_v);
      end
      total++;
      if (lat !== 33 || fb !== 0) begin
        bad++; $display("FAIL div_timing latency=%0d need 33, busy/stall errors=%0d need 0", lat, fb);
      end
    end
  endtask

  task automatic test_divzero();
    logic [1:0]  ops [3] = '{2'b11, 2'b10, 2'b10};
    logic [31:0] as  [3] = '{32'd100, 32'hFFFF_FFFB, 32'h0000_1234};
    logic [63:0] ex  [3] = '{64'h0000_0064_FFFF_FFFF, 64'hFFFF_FFFB_FFFF_FFFF, 64'h0000_1234_FFFF_FFFF};
    logic [63:0] res;
    int lat, fb;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], as[i], 32'h0, res, lat, fb);
      total++;
      if (res !== ex[i] || lat !== 33 || fb !== 0) begin
        bad++;
        $display("FAIL divzero op=%0d a=%h got=%h lat=%0d errs=%0d, need %h lat 33 errs 0",
                 ops[i], as[i], res, lat, fb, ex[i]);
      end
    end
  endtask

  task automatic test_cancel();
    logic [63:0] res;
    int lat, fb, seen;
    do_op(2'b01, 32'd5, 32'd6, res, lat, fb);
    total++;
    if (res !== 64'd30) begin bad++; $display("FAIL cancel_prior got=%h need=%h", res, 64'd30); end
    // start MULTU 3*4 then cancel after ten iterations
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL cancel_abort busy=%b done=%b need 0/0", busy, done);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (done === 1'b1) seen++; end
    total++;
    if (seen !== 0 || result !== 64'd30) begin
      bad++; $display("FAIL cancel_nodone done_pulses=%0d result=%h need 0 and %h", seen, result, 64'd30);
    end
    do_op(2'b01, 32'd3, 32'd4, res, lat, fb);
    total++;
    if (res !== 64'd12 || lat !== 33) begin
      bad++; $display("FAIL cancel_restart got=%h lat=%0d need %h lat 33", res, lat, 64'd12);
    end
    // cancel and start together: nothing accepted
    @(negedge clk);
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL cancel_start_stall got=%b need 0", stall); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    seen = 0;
    repeat (40) begin
      if (busy === 1'b1 || done === 1'b1) seen++;
      @(posedge clk); @(negedge clk);
    end
    total++;
    if (seen !== 0 || result !== 64'd12) begin
      bad++; $display("FAIL cancel_start_ignored activity=%0d result=%h need 0 and %h", seen, result, 64'd12);
    end
  endtask

  task automatic test_start_held();
    int lat;
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 2'b00; a = 32'd7; b = 32'd9;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    start = 1'b0;
    total++;
    if (result !== 64'd12 || lat !== 33) begin
      bad++; $display("FAIL start_held got=%h lat=%0d need %h lat 33", result, lat, 64'd12);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL start_held_idle busy=%b need 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res1, exp1, exp2;
    logic [31:0] x, y;
    int lat, fb, cnt;
    x = $urandom; y = $urandom;
    exp1 = ref_model(2'b00, x, y);
    do_op(2'b00, x, y, res1, lat, fb);
    total++;
    if (res1 !== exp1) begin bad++; $display("FAIL b2b_first got=%h need=%h", res1, exp1); end
    // still in the done cycle: launch the second op immediately
    x = $urandom; y = $urandom | 32'h1;
    exp2 = ref_model(2'b11, x, y);
    op = 2'b11; a = x; b = y; start = 1'b1;
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || result !== exp1) begin
      bad++; $display("FAIL b2b_accept busy=%b result=%h need 1 and %h", busy, result, exp1);
    end
    while (done !== 1'b1 && cnt < 100) begin @(posedge clk); cnt++; @(negedge clk); end
    total++;
    if (cnt !== 34 || result !== exp2) begin
      bad++; $display("FAIL b2b_second edges=%0d result=%h need 34 and %h", cnt, result, exp2);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int lat, fb, seen;
    @(negedge clk);
    op = 2'b10; a = 32'hDEAD_BEEF; b = 32'd17; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 64'h0) begin
      bad++; $display("FAIL reset_mid busy=%b done=%b stall=%b result=%h need all 0", busy, done, stall, result);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL reset_mid_quiet activity=%0d need 0", seen); end
    do_op(2'b11, 32'd100, 32'd7, res, lat, fb);
    total++;
    if (res !== 64'h0000_0002_0000_000E || lat !== 33) begin
      bad++; $display("FAIL reset_mid_recover got=%h lat=%0d need %h lat 33", res, lat, 64'h0000_0002_0000_000E);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_cancel();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
Iterative multiply/divide unit that produces the 64-bit {HI,LO} value written into the register file's HI/LO write port. It sits in the execute stage, takes operands from the operand-forwarding muxes, and stalls the pipeline while an operation is in flight. On completion it presents a result that writeback commits with the "write both HI and LO" flag (3'b111). One radix-2 iteration per cycle; fixed latency for all operations.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits.
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a new operation; sampled only in IDLE.
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
cancel  input  1  pipeline flush (exception/branch squash); aborts the operation.
a  input  WIDTH  rs operand (multiplicand / dividend).
b  input  WIDTH  rt operand (multiplier / divisor).
busy  output  1  high while in RUN or FIN.
stall  output  1  combinational: busy | (start & ~cancel); holds the execute stage.
done  output  1  registered one-cycle pulse: result is valid and must be committed.
result  output  2*WIDTH  [63:32] is HI, [31:0] is LO; held until the next completion.

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, busy=0, done=0, result=0, internal registers=0.
- States: IDLE, RUN, FIN.
- IDLE: when start=1 and cancel=0, latch op, signs, and |a|,|b| (magnitudes only for MULT/DIV), clear the accumulator, set counter=0, go to RUN. Otherwise stay in IDLE.
- RUN: one iteration per edge.
  - Multiply: shift-add, LSB-first.
  - Divide: restoring, MSB-first; a remainder bit is shifted in, the divisor is trial-subtracted, and the quotient bit is set if the result is non-negative.
  - After the edge with counter==WIDTH-1, go to FIN.
- FIN (one edge): apply sign correction, load result, set done=1 for exactly one cycle, return to IDLE.
- Latency: start sampled at edge E0; done is high in the cycle after edge E0+WIDTH+1 (33 edges for WIDTH=32). stall is high from the start cycle through the cycle before done.
- Sign rules:
  - MULT: the product is negated if sign(a)^sign(b).
  - DIV: the quotient is negated if sign(a)^sign(b); the remainder takes the sign of the dividend.
  - Divide result: HI=remainder, LO=quotient.
- Divide by zero (b==0, DIV or DIVU): no trap. LO=all ones, HI=a (original signed dividend, no correction). Latency is unchanged.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This wraps naturally; no special case is needed.
- start while busy: ignored; op/a/b are not re-latched.
- Back-to-back: start is accepted in the IDLE cycle in which done is high.
- cancel: in any state, go to IDLE on the next edge. busy=0, no done pulse, result keeps its old value. If cancel and start are high in the same cycle, cancel wins and nothing is accepted.
- Reset mid-operation: immediate return to reset values; no done pulse.
- done never coincides with busy=1.

Decomposition:
- Package hilo_muldiv_pkg holds:
  - op enum: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum: IDLE, RUN, FIN.
  - HILO_WR_BOTH = 3'b111, for the writeback flag.
  - WIDTH default.
- One sub-module, muldiv_sign_fix: combinational. Takes the raw 64-bit accumulator, op, and operand signs, and applies the negation and divide-by-zero rules. This keeps the iteration datapath unsigned.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done after 33 edges; result=0xFFFFFFFE_00000001; busy/stall high until then.
- MULT a=0xFFFFFFFD (-3) b=5 -> result=0xFFFFFFFF_FFFFFFF1. MULT a=0x80000000 b=0x80000000 -> result=0x40000000_00000000.
- DIV a=0xFFFFFFF9 (-7) b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD. DIVU a=100 b=7 -> HI=2, LO=14. DIV a=0x80000000 b=0xFFFFFFFF -> HI=0, LO=0x80000000.
- DIVU a=100 b=0 -> HI=0x64, LO=0xFFFFFFFF, done after 33 edges; no other signal changes.
- Start MULTU 3*4, assert cancel at iteration 10 -> busy=0 on the next edge; no done; result keeps its prior value. A new start then yields 12 with the full latency. A start held during busy is ignored.
- Assert rst mid-DIV -> outputs go to 0 asynchronously, before the next clock edge. Back-to-back: start a second op in the done cycle -> second done exactly 34 cycles after the first.
